// File: rtl/config_loader.sv
// Configuration stream loader: parses SYNC/COUNT/records/CHK from a byte stream
// and drives a shared CLB config word plus a one-hot per-CLB write strobe.
module config_loader #(
  parameter int          NUM_CLB   = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [7:0]         cfg_data_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  output logic [22:0]        bits_o,
  output logic [NUM_CLB-1:0] wr_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  // state   | meaning
  // IDLE    | hunting for SYNC_BYTE, other bytes dropped
  // COUNT   | expecting record count
  // ADDR    | expecting record CLB address
  // D2      | expecting data byte 2 (bit 7 reserved)
  // D1      | expecting data byte 1
  // D0      | expecting data byte 0, latches bits_o
  // SETUP   | bits_o settling, no strobe
  // WRITE   | one-hot strobe to addressed CLB
  // CHECK   | expecting checksum byte
  // ERR     | one-cycle error state
  typedef enum logic [3:0] {
    IDLE, COUNT, ADDR, D2, D1, D0, SETUP, WRITE, CHECK, ERR
  } state_t;

  localparam int         AW        = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;
  localparam logic [8:0] NUM_CLB_W = 9'(NUM_CLB);

  state_t          state;
  logic [7:0]      cnt_q;
  logic [7:0]      csum_q;
  logic [AW-1:0]   addr_q;
  logic [6:0]      d2_q;
  logic [7:0]      d1_q;
  logic            accept;

  assign accept = cfg_valid_i & cfg_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cfg_ready_o <= 1'b0;
      bits_o      <= '0;
      wr_en_o     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      cnt_q       <= '0;
      csum_q      <= '0;
      addr_q      <= '0;
      d2_q        <= '0;
      d1_q        <= '0;
    end else begin
      done_o  <= 1'b0;
      wr_en_o <= '0;
      case (state)
        IDLE: begin
          cfg_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          if (accept && cfg_data_i == SYNC_BYTE) begin
            state  <= COUNT;
            busy_o <= 1'b1;
            err_o  <= 1'b0;
            csum_q <= '0;
          end
        end
        COUNT: if (accept) begin
          csum_q <= csum_q ^ cfg_data_i;
          if (cfg_data_i == 8'd0 || {1'b0, cfg_data_i} > NUM_CLB_W) begin
            state       <= ERR;
            err_o       <= 1'b1;
            cfg_ready_o <= 1'b0;
          end else begin
            cnt_q <= cfg_data_i;
            state <= ADDR;
          end
        end
        ADDR: if (accept) begin
          csum_q <= csum_q ^ cfg_data_i;
          if ({1'b0, cfg_data_i} >= NUM_CLB_W) begin
            state       <= ERR;
            err_o       <= 1'b1;
            cfg_ready_o <= 1'b0;
          end else begin
            addr_q <= cfg_data_i[AW-1:0];
            state  <= D2;
          end
        end
        D2: if (accept) begin
          csum_q <= csum_q ^ cfg_data_i;
          if (cfg_data_i[7]) begin
            state       <= ERR;
            err_o       <= 1'b1;
            cfg_ready_o <= 1'b0;
          end else begin
            d2_q  <= cfg_data_i[6:0];
            state <= D1;
          end
        end
        D1: if (accept) begin
          csum_q <= csum_q ^ cfg_data_i;
          d1_q   <= cfg_data_i;
          state  <= D0;
        end
        D0: if (accept) begin
          csum_q      <= csum_q ^ cfg_data_i;
          bits_o      <= {d2_q, d1_q, cfg_data_i};
          cfg_ready_o <= 1'b0;
          state       <= SETUP;
        end
        SETUP: begin
          wr_en_o <= {{(NUM_CLB-1){1'b0}}, 1'b1} << addr_q;
          state   <= WRITE;
        end
        WRITE: begin
          cnt_q       <= cnt_q - 8'd1;
          cfg_ready_o <= 1'b1;
          state       <= (cnt_q == 8'd1) ? CHECK : ADDR;
        end
        CHECK: if (accept) begin
          if (cfg_data_i == csum_q) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            state       <= ERR;
            err_o       <= 1'b1;
            cfg_ready_o <= 1'b0;
          end
        end
        ERR: begin
          cfg_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Randomized and directed bench for config_loader, checked against a stream-level
// parser of the load format.
module tb_config_loader;

  localparam int         N    = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic [7:0]    cfg_data_i = 8'h00;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [22:0]   bits_o;
  logic [N-1:0]  wr_en_o;
  logic          busy_o, done_o, err_o;

  config_loader #(.NUM_CLB(N), .SYNC_BYTE(SYNC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o), .bits_o(bits_o), .wr_en_o(wr_en_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int addr; logic [22:0] bits; int idx; } exp_t;
  typedef struct { bit oh; int addr; logic [22:0] bits; int cyc; bit stable; } obs_t;

  int tests = 0, fails = 0;
  int cyc = 0;
  int rdy_low = 0, done_cnt = 0;
  logic [22:0] prev_bits = '0;
  logic [7:0] stim[$];
  exp_t exp_w[$];
  obs_t wr_obs[$];
  int acc_cyc[$];
  int exp_done, exp_err, send_len, sync_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (!cfg_ready_o) rdy_low++;
      if (done_o) done_cnt++;
      if (wr_en_o != '0) begin
        obs_t o;
        o.oh = $onehot(wr_en_o);
        o.addr = -1;
        for (int j = 0; j < N; j++) if (wr_en_o[j]) o.addr = j;
        o.bits = bits_o;
        o.cyc = cyc;
        o.stable = (bits_o == prev_bits);
        wr_obs.push_back(o);
      end
    end
    prev_bits = bits_o;
  end

  // Reference: parse the byte list by the load-format rules.
  task automatic model_parse();
    int i = 0;
    logic [7:0] x, c;
    exp_w.delete();
    exp_done = 0; exp_err = 0;
    while (stim[i] != SYNC) i++;
    sync_idx = i;
    i++;
    c = stim[i];
    x = c;
    if (c == 8'd0 || int'(c) > N) begin exp_err = 1; send_len = i + 1; return; end
    for (int r = 0; r < int'(c); r++) begin
      exp_t e;
      x = x ^ stim[i+1];
      if (int'(stim[i+1]) >= N) begin exp_err = 1; send_len = i + 2; return; end
      x = x ^ stim[i+2];
      if (stim[i+2][7]) begin exp_err = 1; send_len = i + 3; return; end
      x = x ^ stim[i+3] ^ stim[i+4];
      e.addr = int'(stim[i+1]);
      e.bits = {stim[i+2][6:0], stim[i+3], stim[i+4]};
      e.idx  = i + 4;
      exp_w.push_back(e);
      i += 4;
    end
    send_len = i + 2;
    if (stim[i+1] == x) exp_done = 1; else exp_err = 1;
  endtask

  task automatic append_chk();
    logic [7:0] x = 8'h00;
    bit seen = 0;
    foreach (stim[k]) begin
      if (seen) x = x ^ stim[k];
      else if (stim[k] == SYNC) seen = 1;
    end
    stim.push_back(x);
  endtask

  task automatic gen_load(input int ngarb, input int cnt);
    logic [7:0] b;
    stim.delete();
    repeat (ngarb) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      stim.push_back(b);
    end
    stim.push_back(SYNC);
    stim.push_back(8'(cnt));
    for (int r = 0; r < cnt; r++) begin
      stim.push_back(8'($urandom_range(0, N-1)));
      stim.push_back(8'($urandom_range(0, 127)));
      stim.push_back(8'($urandom));
      stim.push_back(8'($urandom));
    end
    append_chk();
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    cfg_valid_i = 1'b1;
    cfg_data_i  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (cfg_ready_o) ok = 1;
      @(negedge clk_i);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input string tag, input int gap_pct);
    model_parse();
    acc_cyc.delete();
    @(negedge clk_i);
    wr_obs.delete();
    done_cnt = 0;
    rdy_low = 0;
    for (int k = 0; k < send_len; k++) begin
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        cfg_valid_i = 1'b0;
        cfg_data_i  = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk_i);
      end
      send_byte(stim[k]);
      acc_cyc.push_back(cyc);
      if (k == sync_idx) check({tag, "_err_clr"}, 32'(err_o), 32'd0);
    end
    cfg_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check({tag, "_nwr"}, 32'(wr_obs.size()), 32'(exp_w.size()));
    for (int w = 0; w < wr_obs.size() && w < exp_w.size(); w++) begin
      check({tag, "_onehot"}, 32'(wr_obs[w].oh), 32'd1);
      check({tag, "_addr"}, 32'(wr_obs[w].addr), 32'(exp_w[w].addr));
      check({tag, "_bits"}, 32'(wr_obs[w].bits), 32'(exp_w[w].bits));
      check({tag, "_stable"}, 32'(wr_obs[w].stable), 32'd1);
      check({tag, "_wtime"}, 32'(wr_obs[w].cyc), 32'(acc_cyc[exp_w[w].idx] + 1));
    end
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_err"}, 32'(err_o), 32'(exp_err));
    check({tag, "_rdylow"}, 32'(rdy_low), 32'(2 * exp_w.size() + exp_err));
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #2;
    check("rst_ready", 32'(cfg_ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_wr", 32'(wr_en_o), 32'd0);
    check("rst_bits", 32'(bits_o), 32'd0);
    check("rst_done_err", 32'({done_o, err_o}), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1 check("rst_rel_ready0", 32'(cfg_ready_o), 32'd0);
    @(negedge clk_i);
    check("rst_rel_ready1", 32'(cfg_ready_o), 32'd1);

    stim = '{SYNC, 8'h01, 8'h03, 8'h00, 8'h12, 8'h34};
    append_chk();
    run_load("single", 0);
    if (wr_obs.size() > 0) begin
      check("single_word", 32'(wr_obs[0].bits), 32'h001234);
      check("single_strobe", 32'(wr_obs[0].addr), 32'd3);
    end

    stim = '{SYNC, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h04, 8'h05, 8'h06};
    append_chk();
    run_load("b2b", 0);
    if (wr_obs.size() == 2) begin
      check("b2b_first", 32'(wr_obs[0].addr), 32'd0);
      check("b2b_second", 32'(wr_obs[1].addr), 32'd15);
    end

    stim = '{SYNC, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load("badaddr", 0);
    stim = '{SYNC, 8'h01, 8'h05, 8'h7F, 8'hFF, 8'hFF};
    append_chk();
    run_load("after_err", 0);

    gen_load(0, 1);
    stim[stim.size()-1] = stim[stim.size()-1] ^ 8'h01;
    run_load("badchk", 0);

    stim = '{SYNC, 8'h00};
    run_load("cnt0", 0);
    stim = '{SYNC, 8'h11};
    run_load("cnt17", 0);
    stim = '{SYNC, 8'h10, 8'h02, 8'h80, 8'h00};
    run_load("rsvd", 0);

    stim = '{8'h00, 8'hFF, SYNC, 8'h02, 8'h09, 8'h11, 8'h22, 8'h33, 8'h0A, 8'h44, 8'h55, 8'h66};
    append_chk();
    run_load("garbage", 40);

    stim = '{SYNC, 8'h02, 8'h07, 8'h11, 8'h22, 8'h33, 8'h07, 8'h44, 8'h55, 8'h66};
    append_chk();
    run_load("sameaddr", 0);

    for (int it = 0; it < 15; it++) begin
      int mode = int'($urandom_range(0, 4));
      gen_load(int'($urandom_range(0, 3)), int'($urandom_range(1, N)));
      if (mode == 3) stim[stim.size()-1] = stim[stim.size()-1] ^ 8'(1 << $urandom_range(0, 7));
      if (mode == 4) stim[stim.size()-5] = 8'($urandom_range(N, 255));
      run_load("rand", 30);
    end

    stim = '{SYNC, 8'h01, 8'h05, 8'h01, 8'h02, 8'h03};
    @(negedge clk_i);
    foreach (stim[k]) send_byte(stim[k]);
    cfg_valid_i = 1'b0;
    @(negedge clk_i);
    check("rstw_strobe", 32'(wr_en_o), 32'h0020);
    #2 rst_ni = 1'b0;
    #1;
    check("rstw_wr", 32'(wr_en_o), 32'd0);
    check("rstw_bits", 32'(bits_o), 32'd0);
    check("rstw_flags", 32'({cfg_ready_o, busy_o, done_o, err_o}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    gen_load(0, 3);
    run_load("post_rst", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
